// File: rtl/lvda_pio_pkg.sv
// Shared types for the LVDA process-I/O receive path: word/address widths,
// the deserializer FSM state encoding and the packed FIFO entry.
package lvda_pio_pkg;

    localparam int WORD_W = 26;
    localparam int ADDR_W = 9;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SYNC   = 2'd1,
        SHIFT  = 2'd2,
        COMMIT = 2'd3
    } state_e;

    // 36-bit entry: PIOV flag, operand address, assembled serial word.
    typedef struct packed {
        logic              pio;
        logic [ADDR_W-1:0] addr;
        logic [WORD_W-1:0] data;
    } fifo_entry_t;

    function automatic fifo_entry_t make_entry(input logic              pio,
                                               input logic [ADDR_W-1:0] addr,
                                               input logic [WORD_W-1:0] data);
        fifo_entry_t e;
        e.pio  = pio;
        e.addr = addr;
        e.data = data;
        return e;
    endfunction

endpackage

// File: rtl/lvda_pio_fifo.sv
// Synchronous FIFO of lvda_pio entries, shared by the LVDA receive paths.
// A push while full is accepted only when a pop happens in the same cycle;
// otherwise it is ignored and the caller decides how to flag the loss.
// Storage is cleared by reset so the head reads as zero after reset.
module lvda_pio_fifo
    import lvda_pio_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  fifo_entry_t            wr_data,
    output logic                   full,
    input  logic                   pop,
    output logic                   empty,
    output fifo_entry_t            rd_data,
    output logic [$clog2(DEPTH):0] fill
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    fifo_entry_t   mem_r [DEPTH];
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [CW-1:0] count_r;
    logic          do_push_s;
    logic          do_pop_s;

    assign full      = (count_r == CW'(DEPTH));
    assign empty     = (count_r == CW'(0));
    assign do_pop_s  = pop & ~empty;
    assign do_push_s = push & (~full | do_pop_s);
    assign rd_data   = mem_r[rd_ptr_r];
    assign fill      = count_r;

    // Storage, pointer and occupancy update; pointers wrap modulo DEPTH.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '0;
            end
            wr_ptr_r <= AW'(0);
            rd_ptr_r <= AW'(0);
            count_r  <= CW'(0);
        end else begin
            if (do_push_s) begin
                mem_r[wr_ptr_r] <= wr_data;
                wr_ptr_r        <= wr_ptr_r + AW'(1);
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/lvda_pio_deser.sv
// LVDA process-I/O receive stage. Deserializes the 26-bit LVDC word on AI3V,
// strobed by WDA and framed by PBV, tags it with A1V..A9V and PIOV, and queues
// it for the LVDA register/discrete logic. Everything runs on SIM_CLK; WDA is
// only sampled as data.
// Optional: define LVDA_PIO_TIMEOUT_EN to abort a frame that stalls for
// TIMEOUT_CYCLES SIM_CLK cycles between WDA edges.
module lvda_pio_deser
    import lvda_pio_pkg::*;
#(
    parameter int DEPTH          = 4,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                   SIM_CLK,
    input  logic                   SIM_RST,
    input  logic                   WDA,
    input  logic                   PBV,
    input  logic                   AI3V,
    input  logic                   PIOV,
    input  logic                   A1V,
    input  logic                   A2V,
    input  logic                   A3V,
    input  logic                   A4V,
    input  logic                   A5V,
    input  logic                   A6V,
    input  logic                   A7V,
    input  logic                   A8V,
    input  logic                   A9V,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [WORD_W-1:0]      out_data,
    output logic [ADDR_W-1:0]      out_addr,
    output logic                   out_pio,
    output logic                   frame_err,
    output logic                   ovf,
    output logic [$clog2(DEPTH):0] fill
);

    // Registered copies of the LVDC lines.
    logic              wda_r;
    logic              wda_prev_r;
    logic              pbv_r;
    logic              pbv_prev_r;
    logic              ai3v_r;
    logic              piov_r;
    logic [ADDR_W-1:0] addr_in_r;

    logic              wedge_s;
    logic              pbv_rise_s;

    // Frame assembly state.
    state_e            state_r;
    state_e            next_state_s;
    logic [WORD_W-1:0] shreg_r;
    logic [4:0]        bitcnt_r;
    logic [ADDR_W-1:0] addr_cap_r;
    logic              pio_cap_r;
    logic              frame_err_r;
    logic              ovf_r;

    logic              load_s;
    logic              shift_s;
    logic              push_s;
    logic              err_s;
    logic              tmo_hit_s;

    logic              fifo_full_s;
    logic              fifo_empty_s;
    fifo_entry_t       head_s;

    assign wedge_s    = wda_r & ~wda_prev_r;
    assign pbv_rise_s = pbv_r & ~pbv_prev_r;

    // Single register stage on every LVDC input, plus the WDA history for edge detection.
    always_ff @(posedge SIM_CLK) begin
        if (!SIM_RST) begin
            wda_r      <= 1'b0;
            wda_prev_r <= 1'b0;
            pbv_r      <= 1'b0;
            ai3v_r     <= 1'b0;
            piov_r     <= 1'b0;
            addr_in_r  <= 9'd0;
        end else begin
            wda_r      <= WDA;
            wda_prev_r <= wda_r;
            pbv_r      <= PBV;
            ai3v_r     <= AI3V;
            piov_r     <= PIOV;
            addr_in_r  <= {A1V, A2V, A3V, A4V, A5V, A6V, A7V, A8V, A9V};
        end
    end

    // PBV history advances only on WDA edges so a rise is judged edge to edge.
    always_ff @(posedge SIM_CLK) begin
        if (!SIM_RST) begin
            pbv_prev_r <= 1'b0;
        end else if (wedge_s) begin
            pbv_prev_r <= pbv_r;
        end else begin
            pbv_prev_r <= pbv_prev_r;
        end
    end

`ifdef LVDA_PIO_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES) + 1;
    logic [TMO_W-1:0] tmo_cnt_r;
    logic             in_frame_s;

    assign in_frame_s = (state_r == SYNC) || (state_r == SHIFT);
    assign tmo_hit_s  = in_frame_s && !wedge_s &&
                        (tmo_cnt_r == TMO_W'(TIMEOUT_CYCLES - 1));

    // Cycles since the last WDA edge while a frame is open.
    always_ff @(posedge SIM_CLK) begin
        if (!SIM_RST) begin
            tmo_cnt_r <= TMO_W'(0);
        end else if (!in_frame_s || wedge_s || tmo_hit_s) begin
            tmo_cnt_r <= TMO_W'(0);
        end else begin
            tmo_cnt_r <= tmo_cnt_r + TMO_W'(1);
        end
    end
`else
    assign tmo_hit_s = 1'b0;
`endif

    // Next-state and control decode; every action is qualified by a WDA edge.
    always_comb begin
        next_state_s = state_r;
        load_s       = 1'b0;
        shift_s      = 1'b0;
        push_s       = 1'b0;
        err_s        = 1'b0;
        case (state_r)
            IDLE: begin
                if (wedge_s && pbv_rise_s) begin
                    load_s       = 1'b1;
                    next_state_s = SYNC;
                end else begin
                    next_state_s = IDLE;
                end
            end
            SYNC: begin
                // Skip edge: carries no data.
                if (wedge_s) begin
                    next_state_s = SHIFT;
                end else if (tmo_hit_s) begin
                    err_s        = 1'b1;
                    next_state_s = IDLE;
                end else begin
                    next_state_s = SYNC;
                end
            end
            SHIFT: begin
                if (wedge_s) begin
                    if (!pbv_r) begin
                        err_s        = 1'b1;
                        next_state_s = IDLE;
                    end else begin
                        shift_s      = 1'b1;
                        next_state_s = (bitcnt_r == 5'd1) ? COMMIT : SHIFT;
                    end
                end else if (tmo_hit_s) begin
                    err_s        = 1'b1;
                    next_state_s = IDLE;
                end else begin
                    next_state_s = SHIFT;
                end
            end
            COMMIT: begin
                // The commit edge also counts as a frame-start candidate.
                if (wedge_s) begin
                    push_s = 1'b1;
                    if (pbv_rise_s) begin
                        load_s       = 1'b1;
                        next_state_s = SYNC;
                    end else begin
                        next_state_s = IDLE;
                    end
                end else begin
                    next_state_s = COMMIT;
                end
            end
            default: begin
                next_state_s = IDLE;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge SIM_CLK) begin
        if (!SIM_RST) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Shift register, bit counter and per-frame address/flag capture.
    always_ff @(posedge SIM_CLK) begin
        if (!SIM_RST) begin
            shreg_r    <= 26'd0;
            bitcnt_r   <= 5'd0;
            addr_cap_r <= 9'd0;
            pio_cap_r  <= 1'b0;
        end else if (load_s) begin
            shreg_r    <= 26'd0;
            bitcnt_r   <= 5'd26;
            addr_cap_r <= addr_in_r;
            pio_cap_r  <= piov_r;
        end else if (shift_s) begin
            // MSB first: the first serial bit ends up in bit 25.
            shreg_r  <= {shreg_r[WORD_W-2:0], ai3v_r};
            bitcnt_r <= bitcnt_r - 5'd1;
        end else begin
            shreg_r  <= shreg_r;
            bitcnt_r <= bitcnt_r;
        end
    end

    // Abort pulse and sticky overflow; a full push is lost only when no pop coincides.
    always_ff @(posedge SIM_CLK) begin
        if (!SIM_RST) begin
            frame_err_r <= 1'b0;
            ovf_r       <= 1'b0;
        end else begin
            frame_err_r <= err_s;
            ovf_r       <= ovf_r | (push_s & fifo_full_s & ~out_ready);
        end
    end

    lvda_pio_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (SIM_CLK),
        .rst_n   (SIM_RST),
        .push    (push_s),
        .wr_data (make_entry(pio_cap_r, addr_cap_r, shreg_r)),
        .full    (fifo_full_s),
        .pop     (out_ready),
        .empty   (fifo_empty_s),
        .rd_data (head_s),
        .fill    (fill)
    );

    assign out_valid = ~fifo_empty_s;
    assign out_data  = head_s.data;
    assign out_addr  = head_s.addr;
    assign out_pio   = head_s.pio;
    assign frame_err = frame_err_r;
    assign ovf       = ovf_r;

endmodule

// File: tb/tb_lvda_pio_deser.sv
// Scoreboard bench for lvda_pio_deser: stimulus drives LVDC-style frames and
// queues the words that should come out; a monitor pops and compares on every
// out_valid/out_ready handshake.
module tb_lvda_pio_deser;
    import lvda_pio_pkg::*;

    localparam int DEPTH = 4;

    logic        sim_clk = 1'b0;
    logic        sim_rst;
    logic        wda, pbv, ai3v, piov;
    logic [8:0]  a_pins;
    logic        out_valid, out_ready;
    logic [25:0] out_data;
    logic [8:0]  out_addr;
    logic        out_pio, frame_err, ovf;
    logic [2:0]  fill;

    int          checks   = 0;
    int          failures = 0;
    fifo_entry_t sb[$];
    bit          rand_ready = 1'b0;
    bit          exp_ovf    = 1'b0;
    fifo_entry_t mon_e;
    bit          prev_hold  = 1'b0;
    logic [36:0] prev_word;

    always #5 sim_clk = ~sim_clk;

    lvda_pio_deser #(.DEPTH(DEPTH), .TIMEOUT_CYCLES(64)) dut (
        .SIM_CLK(sim_clk), .SIM_RST(sim_rst), .WDA(wda), .PBV(pbv), .AI3V(ai3v), .PIOV(piov),
        .A1V(a_pins[8]), .A2V(a_pins[7]), .A3V(a_pins[6]), .A4V(a_pins[5]), .A5V(a_pins[4]),
        .A6V(a_pins[3]), .A7V(a_pins[2]), .A8V(a_pins[1]), .A9V(a_pins[0]),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_addr(out_addr), .out_pio(out_pio), .frame_err(frame_err), .ovf(ovf), .fill(fill)
    );

    task automatic chk(input string name, input logic [36:0] act, input logic [36:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Monitor: samples 2ns after the negedge, when the bench inputs have settled.
    always @(negedge sim_clk) begin
        #2;
        if (sim_rst) begin
            if (prev_hold)
                chk("hold_stable", {out_valid, out_pio, out_addr, out_data}, prev_word);
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_pop actual=%h expected=none", out_data);
                end else begin
                    mon_e = sb.pop_front();
                    chk("pop_data", 37'(out_data), 37'(mon_e.data));
                    chk("pop_addr", 37'(out_addr), 37'(mon_e.addr));
                    chk("pop_pio",  37'(out_pio),  37'(mon_e.pio));
                end
            end
        end
        prev_hold = sim_rst && out_valid && !out_ready;
        prev_word = {out_valid, out_pio, out_addr, out_data};
    end

    // Random consumer backpressure while enabled.
    always @(negedge sim_clk) begin
        if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
    end

    // One WDA strobe: high two cycles, then low for one to three cycles.
    task automatic wedge_bit(input logic p, input logic d);
        @(negedge sim_clk);
        pbv = p; ai3v = d; wda = 1'b1;
        @(negedge sim_clk);
        @(negedge sim_clk);
        wda = 1'b0;
        repeat ($urandom_range(0, 2)) @(negedge sim_clk);
    endtask

    // PBV-rise edge and skip edge; the address pins are scrambled afterwards
    // because the word must keep the value present at the rise.
    task automatic frame_head(input logic [8:0] addr, input logic pio);
        a_pins = addr;
        piov   = pio;
        wedge_bit(1'b1, 1'($urandom));
        a_pins = 9'($urandom);
        piov   = 1'($urandom);
        wedge_bit(1'b1, 1'($urandom));
    endtask

    task automatic data_bits(input logic [25:0] data, input int n);
        for (int i = 25; i > 25 - n; i--) wedge_bit(1'b1, data[i]);
    endtask

    // Commit edge (PBV low so the next frame sees a fresh rise). Updates the model first.
    task automatic commit_edge(input logic [8:0] addr, input logic pio, input logic [25:0] data,
                               input bit pop_pulse, input bit check_lat);
        if (sb.size() >= DEPTH && !pop_pulse) exp_ovf = 1'b1;
        else sb.push_back(make_entry(pio, addr, data));
        @(negedge sim_clk);
        pbv = 1'b0; ai3v = 1'($urandom); wda = 1'b1;
        @(negedge sim_clk);
        if (pop_pulse) out_ready = 1'b1;
        if (check_lat) chk("valid_in_commit_cycle", 37'(out_valid), 37'd0);
        @(negedge sim_clk);
        if (pop_pulse) out_ready = 1'b0;
        wda = 1'b0;
        if (check_lat) chk("valid_after_commit", 37'(out_valid), 37'd1);
        repeat ($urandom_range(0, 2)) @(negedge sim_clk);
    endtask

    task automatic send_frame(input logic [8:0] addr, input logic pio, input logic [25:0] data,
                              input bit pop_pulse);
        frame_head(addr, pio);
        data_bits(data, 26);
        commit_edge(addr, pio, data, pop_pulse, 1'b0);
    endtask

    task automatic wait_drain();
        int n = 0;
        while (sb.size() != 0 && n < 400) begin
            @(negedge sim_clk);
            n++;
        end
        chk("drain_complete", 37'(sb.size()), 37'd0);
        @(negedge sim_clk);
        @(negedge sim_clk);
        chk("drained_valid", 37'(out_valid), 37'd0);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_valid"}, 37'(out_valid), 37'd0);
        chk({tag, "_data"},  37'(out_data),  37'd0);
        chk({tag, "_addr"},  37'(out_addr),  37'd0);
        chk({tag, "_pio"},   37'(out_pio),   37'd0);
        chk({tag, "_ferr"},  37'(frame_err), 37'd0);
        chk({tag, "_ovf"},   37'(ovf),       37'd0);
        chk({tag, "_fill"},  37'(fill),      37'd0);
    endtask

    task automatic do_reset();
        @(negedge sim_clk);
        sim_rst = 1'b0;
        sb.delete();
        exp_ovf = 1'b0;
        @(negedge sim_clk);
        @(negedge sim_clk);
        sim_rst = 1'b1;
    endtask

    // Watchdog: the run must always end on its own.
    initial begin
        #600000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [25:0] d;
        logic [8:0]  ad;
        logic        pf;
        sim_rst = 1'b0; wda = 1'b0; pbv = 1'b0; ai3v = 1'b0; piov = 1'b0;
        a_pins = 9'd0; out_ready = 1'b0;
        do_reset();
        check_all_zero("reset");

        // Single frame with latency check.
        frame_head(9'h1A5, 1'b1);
        data_bits(26'h2AAAAAA, 26);
        commit_edge(9'h1A5, 1'b1, 26'h2AAAAAA, 1'b0, 1'b1);
        out_ready = 1'b1;
        wait_drain();

        // Randomized frames with random backpressure.
        rand_ready = 1'b1;
        for (int k = 0; k < 12; k++) begin
            d = 26'($urandom); ad = 9'($urandom); pf = 1'($urandom);
            send_frame(ad, pf, d, 1'b0);
        end
        rand_ready = 1'b0;
        out_ready  = 1'b1;
        wait_drain();
        chk("random_ovf", 37'(ovf), 37'(exp_ovf));

        // Backpressure: DEPTH+1 frames, the last one is lost.
        out_ready = 1'b0;
        for (int k = 1; k <= DEPTH + 1; k++)
            send_frame(9'($urandom), 1'($urandom), 26'(k), 1'b0);
        chk("bp_fill", 37'(fill), 37'(DEPTH));
        chk("bp_ovf", 37'(ovf), 37'(exp_ovf));
        chk("bp_ovf_set", 37'(ovf), 37'd1);
        out_ready = 1'b1;
        wait_drain();
        chk("bp_ovf_sticky", 37'(ovf), 37'd1);

        // Full FIFO with a pop coinciding with the push.
        do_reset();
        chk("ovf_cleared", 37'(ovf), 37'd0);
        out_ready = 1'b0;
        for (int k = 1; k <= DEPTH; k++)
            send_frame(9'($urandom), 1'($urandom), 26'(k), 1'b0);
        chk("full_fill", 37'(fill), 37'(DEPTH));
        send_frame(9'h0F0, 1'b0, 26'(DEPTH + 1), 1'b1);
        chk("fullpop_fill", 37'(fill), 37'(DEPTH));
        chk("fullpop_ovf", 37'(ovf), 37'd0);
        out_ready = 1'b1;
        wait_drain();

        // Early PBV drop after 10 data bits.
        frame_head(9'h033, 1'b1);
        data_bits(26'h1234567, 10);
        @(negedge sim_clk);
        pbv = 1'b0; wda = 1'b1;
        @(negedge sim_clk);
        chk("ferr_before", 37'(frame_err), 37'd0);
        @(negedge sim_clk);
        wda = 1'b0;
        chk("ferr_pulse", 37'(frame_err), 37'd1);
        @(negedge sim_clk);
        chk("ferr_one_cycle", 37'(frame_err), 37'd0);
        chk("ferr_no_push", 37'(fill), 37'd0);
        send_frame(9'h155, 1'b0, 26'h0C3A5F1, 1'b0);
        wait_drain();

        // Mid-frame reset at bit 13 with a word waiting in the FIFO.
        out_ready = 1'b0;
        send_frame(9'h0AA, 1'b1, 26'h1555555, 1'b0);
        chk("pre_reset_fill", 37'(fill), 37'd1);
        frame_head(9'h1FF, 1'b1);
        data_bits(26'h2DEADBE, 13);
        do_reset();
        pbv = 1'b0;
        check_all_zero("midrst");
        out_ready = 1'b1;
        send_frame(9'h101, 1'b1, 26'h3FFFFFF, 1'b0);
        wait_drain();
        chk("final_ovf", 37'(ovf), 37'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
